// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: the fetch state
// encoding, the PC step, the ARM PC read offset and the bubble instruction
// word presented to decode when nothing valid is available.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          INST_W      = 32;
    localparam logic [31:0] PC_STEP     = 32'd4;
    localparam logic [31:0] PC_READ_OFS = 32'd8;
    localparam logic [31:0] BUBBLE      = 32'h0000_0000;

    // EMPTY : nothing valid on imemRdata
    // RUN   : imemRdata holds the word at resp_pc
    // HOLD  : decode is stalled, the word it is looking at lives in the skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// -----------------------------------------------------------------------------
// fetch_skid
// One-entry holding register for an instruction word and its address.
// Captures the word sitting on the memory read port when decode stalls, so
// the memory can keep streaming without losing that word.
//
// Ports:
//   clk       core clock
//   srst      synchronous active-high reset (empties the entry)
//   clear     drop the held entry (redirect)
//   load      capture data_in/pc_in (clear has priority)
//   data_in   instruction word to capture
//   pc_in     address of data_in
//   data_out  held instruction word
//   pc_out    address of the held word
// -----------------------------------------------------------------------------
module fetch_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic [W-1:0] pc_in,
    output logic [W-1:0] data_out,
    output logic [W-1:0] pc_out
);
    import fetch_pkg::*;

    logic [W-1:0] data_q, data_d;
    logic [W-1:0] pc_q,   pc_d;

    always_comb begin
        data_d = data_q;
        pc_d   = pc_q;
        if (clear) begin
            data_d = W'(BUBBLE);
            pc_d   = '0;
        end else if (load) begin
            data_d = data_in;
            pc_d   = pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            data_q <= W'(BUBBLE);
            pc_q   <= '0;
        end else begin
            data_q <= data_d;
            pc_q   <= pc_d;
        end
    end

    assign data_out = data_q;
    assign pc_out   = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, drives a synchronous instruction
// memory with one cycle of read latency, and feeds the fetch/decode pipe
// register. A one-entry skid absorbs decode stalls so every fetched word is
// delivered exactly once. Taken branches from execute redirect fetch and
// squash whatever is currently presented.
//
// Ports:
//   clk           core clock
//   reset         synchronous active-high reset
//   stall         hazard unit: hold fetch and the current output
//   branchTaken   execute: redirect fetch this cycle
//   branchTarget  redirect address (low two bits forced to zero)
//   imemAddr      registered instruction memory address
//   imemRdata     memory data for the address presented last cycle
//   instOut       instruction to the fetch/decode pipe
//   pcOut         address of instOut
//   pcPlus8       pcOut + 8 (ARM PC read value)
//   instValid     instOut is a real, on-path instruction
//   deE           fetch/decode pipe enable
//   deClear       fetch/decode pipe clear (loads a bubble)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branchTaken,
    input  logic [INST_W-1:0] branchTarget,
    output logic [INST_W-1:0] imemAddr,
    input  logic [INST_W-1:0] imemRdata,
    output logic [INST_W-1:0] instOut,
    output logic [INST_W-1:0] pcOut,
    output logic [INST_W-1:0] pcPlus8,
    output logic              instValid,
    output logic              deE,
    output logic              deClear
);
    import fetch_pkg::*;

    fetch_state_e      state_q,   state_d;
    logic [INST_W-1:0] req_pc_q,  req_pc_d;   // address on the memory port
    logic [INST_W-1:0] resp_pc_q, resp_pc_d;  // address whose data is on imemRdata

    logic              skid_load;
    logic              skid_clear;
    logic [INST_W-1:0] skid_data;
    logic [INST_W-1:0] skid_pc;

    logic [INST_W-1:0] target_aligned;
    logic [INST_W-1:0] inst_mux;
    logic [INST_W-1:0] pc_mux;
    logic              unused_target_lsbs;

    // Word-aligned redirect address; the byte offset bits are dropped.
    assign target_aligned     = {branchTarget[INST_W-1:2], 2'b00};
    assign unused_target_lsbs = ^branchTarget[1:0];

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        resp_pc_d  = resp_pc_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        inst_mux   = INST_W'(BUBBLE);
        pc_mux     = req_pc_q;

        case (state_q)
            EMPTY: begin
                if (!stall) begin
                    state_d   = RUN;
                    resp_pc_d = req_pc_q;
                    req_pc_d  = req_pc_q + INST_W'(PC_STEP);
                end
            end
            RUN: begin
                inst_mux = imemRdata;
                pc_mux   = resp_pc_q;
                if (stall) begin
                    // Park the presented word; the memory keeps re-reading
                    // req_pc so its data is ready again on release.
                    state_d   = HOLD;
                    skid_load = 1'b1;
                end else begin
                    resp_pc_d = req_pc_q;
                    req_pc_d  = req_pc_q + INST_W'(PC_STEP);
                end
            end
            HOLD: begin
                inst_mux = skid_data;
                pc_mux   = skid_pc;
                if (!stall) begin
                    state_d   = RUN;
                    resp_pc_d = req_pc_q;
                    req_pc_d  = req_pc_q + INST_W'(PC_STEP);
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // A redirect overrides any stall or advance decided above.
        if (branchTaken) begin
            state_d    = EMPTY;
            req_pc_d   = target_aligned;
            skid_load  = 1'b0;
            skid_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            req_pc_q  <= INST_W'(RESET_PC);
            resp_pc_q <= INST_W'(RESET_PC);
        end else begin
            state_q   <= state_d;
            req_pc_q  <= req_pc_d;
            resp_pc_q <= resp_pc_d;
        end
    end

    fetch_skid #(
        .W (INST_W)
    ) u_skid (
        .clk      (clk),
        .srst     (reset),
        .clear    (skid_clear),
        .load     (skid_load),
        .data_in  (imemRdata),
        .pc_in    (resp_pc_q),
        .data_out (skid_data),
        .pc_out   (skid_pc)
    );

    assign imemAddr  = req_pc_q;
    assign instOut   = inst_mux;
    assign pcOut     = pc_mux;
    assign pcPlus8   = pc_mux + INST_W'(PC_READ_OFS);
    assign instValid = ((state_q == RUN) || (state_q == HOLD)) && !branchTaken;
    assign deE       = !stall;
    assign deClear   = reset || branchTaken || ((state_q == EMPTY) && !stall);

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Two fetch stages (RESET_PC = 0 and RESET_PC = FFFF_FFF8) share the same
// control stimulus, each with its own synchronous instruction memory. The
// reference model tracks the instruction stream seen by decode: the address
// of the next word decode must accept, and whether a word is available yet.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] PC_A = 32'h0000_0000;
    localparam logic [31:0] PC_B = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] branchTarget = 32'h0;

    logic [31:0] addr_a, rdata_a, inst_a, pc_a, pc8_a;
    logic        valid_a, de_e_a, de_clear_a;
    logic [31:0] addr_b, rdata_b, inst_b, pc_b, pc8_b;
    logic        valid_b, de_e_b, de_clear_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state: next address decode should receive, and whether a word
    // is available (at least one unstalled cycle since the last redirect).
    logic [31:0] nxt_a = 32'h0;
    logic [31:0] nxt_b = 32'h0;
    bit          warm  = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    always @(posedge clk) begin
        rdata_a <= mem_word(addr_a);
        rdata_b <= mem_word(addr_b);
    end

    fetch_stage #(.RESET_PC(PC_A), .INST_W(32)) u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .imemAddr     (addr_a),
        .imemRdata    (rdata_a),
        .instOut      (inst_a),
        .pcOut        (pc_a),
        .pcPlus8      (pc8_a),
        .instValid    (valid_a),
        .deE          (de_e_a),
        .deClear      (de_clear_a)
    );

    fetch_stage #(.RESET_PC(PC_B), .INST_W(32)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .imemAddr     (addr_b),
        .imemRdata    (rdata_b),
        .instOut      (inst_b),
        .pcOut        (pc_b),
        .pcPlus8      (pc8_b),
        .instValid    (valid_b),
        .deE          (de_e_b),
        .deClear      (de_clear_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL cyc %0d %s: got %08h expected %08h", cyc, tag, got, exp);
        end
    endtask

    task automatic check_dut(
        input string       id,
        input logic [31:0] nxt,
        input bit          r,
        input bit          b,
        input bit          s,
        input logic [31:0] addr,
        input logic [31:0] inst,
        input logic [31:0] pc,
        input logic [31:0] pc8,
        input logic        valid,
        input logic        de_e,
        input logic        de_clear
    );
        check({id, ".deE"}, 32'(de_e), 32'(!s));
        if (r) begin
            check({id, ".deClear_rst"}, 32'(de_clear), 32'd1);
        end else if (b) begin
            check({id, ".instValid_br"}, 32'(valid), 32'd0);
            check({id, ".deClear_br"}, 32'(de_clear), 32'd1);
        end else if (warm) begin
            check({id, ".instValid"}, 32'(valid), 32'd1);
            check({id, ".pcOut"}, pc, nxt);
            check({id, ".instOut"}, inst, mem_word(nxt));
            check({id, ".pcPlus8"}, pc8, nxt + 32'd8);
            check({id, ".imemAddr"}, addr, nxt + 32'd4);
            check({id, ".deClear"}, 32'(de_clear), 32'd0);
        end else begin
            check({id, ".instValid_e"}, 32'(valid), 32'd0);
            check({id, ".instOut_e"}, inst, 32'h0);
            check({id, ".pcOut_e"}, pc, nxt);
            check({id, ".pcPlus8_e"}, pc8, nxt + 32'd8);
            check({id, ".imemAddr_e"}, addr, nxt);
            check({id, ".deClear_e"}, 32'(de_clear), 32'(!s));
        end
    endtask

    // One clock cycle: apply inputs after the falling edge, check the
    // combinational view, then advance the model for the coming rising edge.
    task automatic step(input bit r, input bit b, input logic [31:0] t, input bit s);
        @(negedge clk);
        reset        = r;
        branchTaken  = b;
        branchTarget = t;
        stall        = s;
        #1;
        check_dut("A", nxt_a, r, b, s, addr_a, inst_a, pc_a, pc8_a, valid_a, de_e_a, de_clear_a);
        check_dut("B", nxt_b, r, b, s, addr_b, inst_b, pc_b, pc8_b, valid_b, de_e_b, de_clear_b);
        $display("cyc %0d rst=%b br=%b tgt=%08h stall=%b | A pc=%08h inst=%08h v=%b | B pc=%08h inst=%08h v=%b",
                 cyc, r, b, t, s, pc_a, inst_a, valid_a, pc_b, inst_b, valid_b);
        if (r) begin
            nxt_a = PC_A;
            nxt_b = PC_B;
            warm  = 1'b0;
        end else if (b) begin
            nxt_a = t & ~32'h3;
            nxt_b = t & ~32'h3;
            warm  = 1'b0;
        end else if (!s) begin
            if (warm) begin
                nxt_a = nxt_a + 32'd4;
                nxt_b = nxt_b + 32'd4;
            end
            warm = 1'b1;
        end
        cyc++;
    endtask

    initial begin
        logic [31:0] tgt;
        int          sel;

        // Reset, then sequential fetch (B wraps through 0 here).
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Three-cycle stall while A presents 0x10, then release.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Redirect to an unaligned target.
        step(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Branch together with stall while holding.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Reset while holding a skid word.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Stall right after a redirect (stall in the empty state).
        step(1'b0, 1'b1, 32'h0000_0FFE, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      tgt = $urandom;
            else if (sel == 1) tgt = 32'($urandom_range(0, 4095));
            else               tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 6),
                 tgt,
                 ($urandom_range(0, 99) < 30));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
